load_store_unit: RTL and testbench

- Data-memory access stage directly downstream of the instruction decoder.
- Consumes the decoder's `mem_write`, `data_size` and `extension_type` signals, plus the ALU-computed address and rs2 store data.
- Runs a req/ack handshake to the data-memory bus and stalls the single-cycle core while the access is outstanding.
- Returns the byte/half/word-extracted, sign- or zero-extended load result to the writeback mux.

---
 rtl/load_store_unit.sv | 187 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory load/store stage with req/ack bus handshake and timeout
// Stalls the core while a bus access is outstanding and returns the extended load result in DONE.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  data_size,
  input  logic        extension_type,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q,     state_d;
  logic [7:0]  cnt_q,       cnt_d;
  logic        bus_req_q,   bus_req_d;
  logic        bus_we_q,    bus_we_d;
  logic [31:0] bus_addr_q,  bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [3:0]  bus_wstrb_q, bus_wstrb_d;
  logic [1:0]  size_q,      size_d;
  logic        ext_q,       ext_d;
  logic [1:0]  off_q,       off_d;
  logic [31:0] load_q,      load_d;
  logic        err_q,       err_d;

  logic        access;
  logic        aligned;
  logic [31:0] lane_wdata;
  logic [3:0]  lane_wstrb;
  logic [31:0] ext_rdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  assign access = mem_read | mem_write;

  always_comb begin
    aligned    = 1'b1;
    lane_wdata = store_data;
    lane_wstrb = 4'b1111;
    case (data_size)
      2'b00: begin
        aligned    = 1'b1;
        lane_wdata = {4{store_data[7:0]}};
        lane_wstrb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        aligned    = ~addr[0];
        lane_wdata = {2{store_data[15:0]}};
        lane_wstrb = 4'b0011 << addr[1:0];
      end
      default: begin
        aligned    = (addr[1:0] == 2'b00);
        lane_wdata = store_data;
        lane_wstrb = 4'b1111;
      end
    endcase
  end

  // Extraction uses the offset/size latched at launch, not the live decoder inputs.
  always_comb begin
    rd_byte = bus_rdata[7:0];
    case (off_q)
      2'd0:    rd_byte = bus_rdata[7:0];
      2'd1:    rd_byte = bus_rdata[15:8];
      2'd2:    rd_byte = bus_rdata[23:16];
      default: rd_byte = bus_rdata[31:24];
    endcase
    rd_half = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_q)
      2'b00:   ext_rdata = ext_q ? {24'b0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
      2'b01:   ext_rdata = ext_q ? {16'b0, rd_half} : {{16{rd_half[15]}}, rd_half};
      default: ext_rdata = bus_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_wstrb_d = bus_wstrb_q;
    size_d      = size_q;
    ext_d       = ext_q;
    off_d       = off_q;
    load_d      = load_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        cnt_d  = 8'd0;
        load_d = 32'd0;
        err_d  = 1'b0;
        if (access && aligned) begin
          state_d     = S_REQ;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_write;
          bus_addr_d  = {addr[31:2], 2'b00};
          bus_wdata_d = mem_write ? lane_wdata : 32'd0;
          bus_wstrb_d = mem_write ? lane_wstrb : 4'b0000;
          size_d      = data_size;
          ext_d       = extension_type;
          off_d       = addr[1:0];
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 8'd1;
        // Ack has priority over a timeout landing on the same cycle.
        if (bus_ack || cnt_q == LAST_CNT) begin
          state_d     = S_DONE;
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = 32'd0;
          bus_wdata_d = 32'd0;
          bus_wstrb_d = 4'b0000;
          err_d       = ~bus_ack;
          load_d      = (bus_ack && !bus_we_q) ? ext_rdata : 32'd0;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      bus_wstrb_q <= 4'b0000;
      size_q      <= 2'b00;
      ext_q       <= 1'b0;
      off_q       <= 2'b00;
      load_q      <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_wstrb_q <= bus_wstrb_d;
      size_q      <= size_d;
      ext_q       <= ext_d;
      off_q       <= off_d;
      load_q      <= load_d;
      err_q       <= err_d;
    end
  end

  // Gate the combinational IDLE outputs with rst_n so reset silences them even with requests present.
  assign stall      = rst_n & (((state_q == S_IDLE) & access & aligned) | (state_q == S_REQ));
  assign misaligned = rst_n & (state_q == S_IDLE) & access & ~aligned;
  assign load_data  = (state_q == S_DONE) ? load_q : 32'd0;
  assign bus_error  = (state_q == S_DONE) & err_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_wdata  = bus_wdata_q;
  assign bus_wstrb  = bus_wstrb_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - table-driven scoreboard bench for load_store_unit
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0, extension_type = 1'b0;
  logic [1:0]  data_size = 2'b00;
  logic [31:0] addr = '0, store_data = '0, bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic [31:0] load_data, bus_addr, bus_wdata;
  logic        stall, misaligned, bus_error, bus_req, bus_we;
  logic [3:0]  bus_wstrb;

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .data_size(data_size), .extension_type(extension_type), .addr(addr),
    .store_data(store_data), .load_data(load_data), .stall(stall),
    .misaligned(misaligned), .bus_error(bus_error), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr;
    logic [1:0]  size;
    logic        ext;
    logic [31:0] addr, sdata, rdata;
    int          ack_delay;
    logic        exp_mis, exp_we;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata, exp_load;
    logic        exp_err;
    int          exp_stall, exp_req;
  } vec_t;

  typedef struct {
    logic [31:0] load;
    logic        err;
  } exp_t;

  vec_t vecs[15];
  exp_t sb[$];
  int   n_vec = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    mem_read = 0; mem_write = 0; data_size = 0; extension_type = 0;
    addr = 0; store_data = 0; bus_ack = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    exp_t e;
    int   stalls, reqs;
    bit   done;
    @(negedge clk);
    mem_read = v.rd; mem_write = v.wr; data_size = v.size; extension_type = v.ext;
    addr = v.addr; store_data = v.sdata;
    sb.push_back('{v.exp_load, v.exp_err});
    #1;
    chk($sformatf("v%0d misaligned", idx), 32'(misaligned), 32'(v.exp_mis));
    chk($sformatf("v%0d idle_stall", idx), 32'(stall), 32'((v.rd | v.wr) & ~v.exp_mis));
    if (!(v.rd | v.wr) || v.exp_mis) begin
      e = sb.pop_front();
      chk($sformatf("v%0d idle_load", idx), load_data, e.load);
      @(negedge clk);
      chk($sformatf("v%0d no_req", idx), 32'(bus_req), 32'd0);
      clear_inputs();
      return;
    end
    stalls = 1; reqs = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      if (bus_req) begin
        reqs++;
        stalls += stall ? 1 : 0;
        if (reqs == 1) begin
          chk($sformatf("v%0d bus_addr", idx), bus_addr, {v.addr[31:2], 2'b00});
          chk($sformatf("v%0d bus_we", idx), 32'(bus_we), 32'(v.exp_we));
          chk($sformatf("v%0d bus_wstrb", idx), 32'(bus_wstrb), 32'(v.exp_wstrb));
          if (v.wr) chk($sformatf("v%0d bus_wdata", idx), bus_wdata, v.exp_wdata);
        end
        bus_ack   = ((reqs - 1) == v.ack_delay);
        bus_rdata = v.rdata;
      end else begin
        bus_ack = 0;
        chk($sformatf("v%0d done_stall", idx), 32'(stall), 32'd0);
        if (sb.size() == 0) begin
          n_vec++; n_fail++;
          $display("FAIL v%0d scoreboard_empty", idx);
        end else begin
          e = sb.pop_front();
          chk($sformatf("v%0d load_data", idx), load_data, e.load);
          chk($sformatf("v%0d bus_error", idx), 32'(bus_error), 32'(e.err));
        end
        done = 1;
        clear_inputs();
      end
    end
    if (!done) begin
      n_vec++; n_fail++;
      $display("FAIL v%0d done_timeout: got no DONE expected DONE within 64 cycles", idx);
      clear_inputs();
      sb.delete();
    end
    chk($sformatf("v%0d stall_cycles", idx), 32'(stalls), 32'(v.exp_stall));
    chk($sformatf("v%0d req_cycles", idx), 32'(reqs), 32'(v.exp_req));
    @(negedge clk);
    chk($sformatf("v%0d idle_load_zero", idx), load_data, 32'd0);
    chk($sformatf("v%0d idle_err_zero", idx), 32'(bus_error), 32'd0);
  endtask

  initial begin
    //          rd wr size ext addr          sdata         rdata         ack mis we wstrb    wdata         load          err stl req
    vecs[0]  = '{1, 0, 2'd2, 0, 32'h104, 32'h0,        32'hDEADBEEF, 1,  0, 0, 4'b0000, 32'h0,        32'hDEADBEEF, 0, 3,  2};
    vecs[1]  = '{1, 0, 2'd0, 0, 32'h203, 32'h0,        32'h80112233, 0,  0, 0, 4'b0000, 32'h0,        32'hFFFFFF80, 0, 2,  1};
    vecs[2]  = '{1, 0, 2'd0, 1, 32'h203, 32'h0,        32'h80112233, 0,  0, 0, 4'b0000, 32'h0,        32'h00000080, 0, 2,  1};
    vecs[3]  = '{0, 1, 2'd1, 0, 32'h302, 32'h0000ABCD, 32'h0,        0,  0, 1, 4'b1100, 32'hABCDABCD, 32'h0,        0, 2,  1};
    vecs[4]  = '{0, 1, 2'd0, 0, 32'h301, 32'h0000005A, 32'h0,        2,  0, 1, 4'b0010, 32'h5A5A5A5A, 32'h0,        0, 4,  3};
    vecs[5]  = '{1, 0, 2'd2, 0, 32'h106, 32'h0,        32'h0,        0,  1, 0, 4'b0000, 32'h0,        32'h0,        0, 0,  0};
    vecs[6]  = '{1, 0, 2'd1, 0, 32'h102, 32'h0,        32'h80011234, 0,  0, 0, 4'b0000, 32'h0,        32'hFFFF8001, 0, 2,  1};
    vecs[7]  = '{1, 0, 2'd1, 1, 32'h100, 32'h0,        32'h1234F00F, 0,  0, 0, 4'b0000, 32'h0,        32'h0000F00F, 0, 2,  1};
    vecs[8]  = '{0, 1, 2'd2, 0, 32'h10C, 32'h12345678, 32'h0,        0,  0, 1, 4'b1111, 32'h12345678, 32'h0,        0, 2,  1};
    vecs[9]  = '{1, 0, 2'd1, 0, 32'h101, 32'h0,        32'h0,        0,  1, 0, 4'b0000, 32'h0,        32'h0,        0, 0,  0};
    vecs[10] = '{1, 1, 2'd3, 0, 32'h020, 32'hCAFEF00D, 32'h0,        0,  0, 1, 4'b1111, 32'hCAFEF00D, 32'h0,        0, 2,  1};
    vecs[11] = '{0, 1, 2'd1, 0, 32'h303, 32'h1111,     32'h0,        0,  1, 0, 4'b0000, 32'h0,        32'h0,        0, 0,  0};
    vecs[12] = '{1, 0, 2'd0, 0, 32'h200, 32'h0,        32'h0000007F, 0,  0, 0, 4'b0000, 32'h0,        32'h0000007F, 0, 2,  1};
    vecs[13] = '{1, 0, 2'd2, 0, 32'h040, 32'h0,        32'h12345678, -1, 0, 0, 4'b0000, 32'h0,        32'h0,        1, 17, 16};
    vecs[14] = '{0, 0, 2'd2, 0, 32'h044, 32'h0,        32'h0,        0,  0, 0, 4'b0000, 32'h0,        32'h0,        0, 0,  0};

    repeat (3) @(negedge clk);
    chk("reset bus_req", 32'(bus_req), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset load_data", load_data, 32'd0);
    chk("reset bus_wstrb", 32'(bus_wstrb), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

    // Reset in the middle of an outstanding read, then a stray ack while idle.
    @(negedge clk);
    mem_read = 1; data_size = 2'd2; addr = 32'h80;
    repeat (3) @(negedge clk);
    chk("midreq bus_req_before", 32'(bus_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midreq bus_req_drop", 32'(bus_req), 32'd0);
    chk("midreq stall_drop", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    @(negedge clk);
    bus_ack = 1; bus_rdata = 32'h55AA55AA;
    #1;
    chk("stray_ack bus_req", 32'(bus_req), 32'd0);
    chk("stray_ack stall", 32'(stall), 32'd0);
    @(negedge clk);
    chk("stray_ack load_data", load_data, 32'd0);
    chk("stray_ack bus_req_next", 32'(bus_req), 32'd0);
    bus_ack = 0;
    run_vec(vecs[0], 100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
